// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, NOP encoding, reset PC default.
package pipeline_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ready;
   logic [DATA_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: squash beats load; hold when neither is asserted.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              squash,
   input  logic [DATA_W-1:0] d_instr,
   input  logic [ADDR_W-1:0] d_pc_plus4,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr    <= DATA_W'(NOP_INSTR);
         pc_plus4 <= '0;
         valid    <= 1'b0;
      end else if (squash) begin
         instr    <= DATA_W'(NOP_INSTR);
         pc_plus4 <= '0;
         valid    <= 1'b0;
      end else if (load) begin
         instr    <= d_instr;
         pc_plus4 <= d_pc_plus4;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem request, one-entry skid buffer and
// redirect/drain handling feeding the IF/ID register.
module if_fetch_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pc_stall,
   input  logic                  IF_ID_stall,
   input  logic                  flush,
   input  logic [ADDR_W-1:0]     redirect_pc,
   if_fetch_stage_if.master      bus,
   output logic [DATA_W-1:0]     IF_ID_instr,
   output logic [ADDR_W-1:0]     IF_ID_pc_plus4,
   output logic                  IF_ID_valid
);

   fetch_state_e      state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx;
   logic [ADDR_W-1:0] drain_addr, drain_addr_nx;
   logic [DATA_W-1:0] skid_instr, skid_instr_nx;
   logic [ADDR_W-1:0] skid_pc4, skid_pc4_nx;
   logic              req_en;

   logic              stall, fire;
   logic [ADDR_W-1:0] pc_plus4, redirect_aligned;
   logic              ifid_load, ifid_squash;
   logic [DATA_W-1:0] ifid_d_instr;
   logic [ADDR_W-1:0] ifid_d_pc4;

   assign stall            = pc_stall | IF_ID_stall;
   assign pc_plus4         = pc + ADDR_W'(4);
   assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

   // req_en keeps the request low for the reset cycle and the one right after.
   assign bus.imem_req  = req_en && (state != HOLD);
   assign bus.imem_addr = (state == DRAIN) ? drain_addr : pc;
   assign fire          = bus.imem_req & bus.imem_ready;

   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      drain_addr_nx = drain_addr;
      skid_instr_nx = skid_instr;
      skid_pc4_nx   = skid_pc4;
      ifid_load     = 1'b0;
      ifid_squash   = 1'b0;
      ifid_d_instr  = bus.imem_rdata;
      ifid_d_pc4    = pc_plus4;

      case (state)
         FETCH: begin
            if (flush) begin
               ifid_squash   = 1'b1;
               pc_nx         = redirect_aligned;
               skid_instr_nx = '0;
               skid_pc4_nx   = '0;
               // An outstanding, unanswered request must complete before redirecting.
               if (bus.imem_req && !bus.imem_ready) begin
                  state_nx      = DRAIN;
                  drain_addr_nx = pc;
               end
            end else if (fire) begin
               if (stall) begin
                  skid_instr_nx = bus.imem_rdata;
                  skid_pc4_nx   = pc_plus4;
                  state_nx      = HOLD;
               end else begin
                  ifid_load = 1'b1;
                  pc_nx     = pc_plus4;
               end
            end else if (!IF_ID_stall) begin
               ifid_squash = 1'b1;
            end
         end

         HOLD: begin
            if (flush) begin
               ifid_squash   = 1'b1;
               pc_nx         = redirect_aligned;
               skid_instr_nx = '0;
               skid_pc4_nx   = '0;
               state_nx      = FETCH;
            end else if (!stall) begin
               ifid_load     = 1'b1;
               ifid_d_instr  = skid_instr;
               ifid_d_pc4    = skid_pc4;
               pc_nx         = pc_plus4;
               skid_instr_nx = '0;
               skid_pc4_nx   = '0;
               state_nx      = FETCH;
            end
         end

         DRAIN: begin
            if (flush) begin
               ifid_squash = 1'b1;
               pc_nx       = redirect_aligned;
            end
            if (fire) begin
               state_nx = FETCH;
            end
         end

         default: state_nx = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         drain_addr <= RESET_PC;
         skid_instr <= '0;
         skid_pc4   <= '0;
         req_en     <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         drain_addr <= drain_addr_nx;
         skid_instr <= skid_instr_nx;
         skid_pc4   <= skid_pc4_nx;
         req_en     <= 1'b1;
      end
   end

   if_id_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ifid_load),
      .squash     (ifid_squash),
      .d_instr    (ifid_d_instr),
      .d_pc_plus4 (ifid_d_pc4),
      .instr      (IF_ID_instr),
      .pc_plus4   (IF_ID_pc_plus4),
      .valid      (IF_ID_valid)
   );

endmodule
